// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition encodings and the branch resolver FSM states.
package cpu_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    SHADOW
  } bru_state_t;

endpackage

// File: rtl/branch_comparator.sv
// Evaluates a conditional branch's direction from its two operands and funct3.
module branch_comparator
  import cpu_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  output logic        taken
);

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      BR_EQ:   taken = (rs1 == rs2);
      BR_NE:   taken = (rs1 != rs2);
      BR_LT:   taken = (rs1_s < rs2_s);
      BR_GE:   taken = (rs1_s >= rs2_s);
      BR_LTU:  taken = (rs1 < rs2);
      BR_GEU:  taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: resolves branch/jal/jalr, checks the fetch prediction, drives
// predictor update, redirect and flushes exactly once per control instruction, keeps perf counters.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int PHT_IDX_W     = 5,
  parameter int PERF_W        = 32,
  parameter int SHADOW_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_pred_pc,
  input  logic [PHT_IDX_W-1:0] ex_pht_index,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jal,
  input  logic                 ex_is_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_rs1_data,
  input  logic [31:0]          ex_rs2_data,
  input  logic [31:0]          ex_imm,
  output logic                 is_branch,
  output logic                 is_jal,
  output logic                 is_jalr,
  output logic                 actual_taken,
  output logic [31:0]          actual_branch_target,
  output logic                 prediction_correct,
  output logic [PHT_IDX_W-1:0] pht_update_index,
  output logic [31:0]          ID_EX_pc,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [PERF_W-1:0]    perf_branches,
  output logic [PERF_W-1:0]    perf_mispredicts
);

  localparam bit         HAS_SHADOW  = (SHADOW_CYCLES > 0);
  localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_CYCLES);

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  bru_state_t  state, state_nxt;
  logic        pend_flush, pend_flush_nxt;
  logic [2:0]  shadow_cnt, shadow_cnt_nxt;

  logic        ctrl, br_taken, mispredict, fire;
  logic [31:0] jalr_sum, target, next_pc;

  branch_comparator u_cmp (
    .rs1    (ex_rs1_data),
    .rs2    (ex_rs2_data),
    .funct3 (ex_funct3),
    .taken  (br_taken)
  );

  assign ctrl                 = ex_is_branch | ex_is_jal | ex_is_jalr;
  assign jalr_sum             = ex_rs1_data + ex_imm;
  assign target               = ex_is_jalr ? {jalr_sum[31:1], 1'b0} : ex_pc + ex_imm;
  assign actual_taken         = ex_is_branch ? br_taken : (ex_is_jal | ex_is_jalr);
  assign next_pc              = actual_taken ? target : ex_pc + 32'd4;
  assign mispredict           = (ex_pred_pc != next_pc);
  assign actual_branch_target = target;
  assign prediction_correct   = ~mispredict;
  assign pht_update_index     = ex_pht_index;
  assign ID_EX_pc             = ex_pc;
  assign redirect_pc          = next_pc;

  assign is_branch      = fire & ex_is_branch;
  assign is_jal         = fire & ex_is_jal;
  assign is_jalr        = fire & ex_is_jalr;
  assign redirect_valid = fire & mispredict;
  assign flush_if_id    = fire & mispredict;

  always_comb begin
    state_nxt      = state;
    pend_flush_nxt = pend_flush;
    shadow_cnt_nxt = shadow_cnt;
    flush_id_ex    = 1'b0;
    fire           = 1'b0;
    case (state)
      IDLE: begin
        fire = ex_valid & ctrl;
        if (fire) begin
          if (ex_stall) begin
            state_nxt      = HELD;
            pend_flush_nxt = mispredict;
          end else if (mispredict) begin
            flush_id_ex = 1'b1;
            if (HAS_SHADOW) begin
              state_nxt      = SHADOW;
              shadow_cnt_nxt = SHADOW_INIT;
            end
          end
        end
      end
      // Instruction already reported; its ID/EX flush waits for the stall to release.
      HELD: begin
        if (!ex_stall) begin
          flush_id_ex    = pend_flush;
          pend_flush_nxt = 1'b0;
          state_nxt      = IDLE;
          if (pend_flush && HAS_SHADOW) begin
            state_nxt      = SHADOW;
            shadow_cnt_nxt = SHADOW_INIT;
          end
        end
      end
      SHADOW: begin
        shadow_cnt_nxt = shadow_cnt - 3'd1;
        if (shadow_cnt <= 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pend_flush       <= 1'b0;
      shadow_cnt       <= 3'd0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      state      <= state_nxt;
      pend_flush <= pend_flush_nxt;
      shadow_cnt <= shadow_cnt_nxt;
      if (fire) begin
        perf_branches <= sat_inc(perf_branches);
        if (mispredict) perf_mispredicts <= sat_inc(perf_mispredicts);
      end
    end
  end

endmodule
